// File: rtl/sopc_mem_arbiter_pkg.sv
// rtl/sopc_mem_arbiter_pkg.sv - shared widths and encodings for the SOPC memory arbiter
//
// Purpose: bus widths shared with the core, plus the arbiter state and
// RAM-owner encodings.
// Ports: none (package).
package sopc_mem_arbiter_pkg;

    localparam int INST_ADDR_W = 32;  // instruction address bus
    localparam int INST_W      = 32;  // instruction bus
    localparam int DATA_W      = 32;  // data bus
    localparam int CNT_W       = 4;   // latency and starvation counters (1..15)

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbBusy = 2'd1,
        ArbDone = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIf   = 2'd1,
        OwnMem  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/sopc_mem_arbiter.sv
// rtl/sopc_mem_arbiter.sv - single-port RAM arbiter between fetch and data ports
//
// Purpose: serialises instruction-fetch and data accesses onto one unified
// RAM with a fixed read latency. Data wins ties, except when fetch has lost
// STARVE_MAX consecutive arbitrations. Stall is requested while any
// request is pending.
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   if_*             fetch port: req/addr in, data/ack out
//   mem_*            data port: req/we/sel/addr/wdata in, rdata/ack out
//   stallreq_o       combinational stall request to the pipeline controller
//   ram_*            RAM side: ce/we/sel/addr/wdata out, rdata in
module sopc_mem_arbiter
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [INST_ADDR_W-1:0] if_addr_i,
    output logic [INST_W-1:0]      if_data_o,
    output logic                   if_ack_o,
    input  logic                   mem_req_i,
    input  logic                   mem_we_i,
    input  logic [3:0]             mem_sel_i,
    input  logic [DATA_W-1:0]      mem_addr_i,
    input  logic [DATA_W-1:0]      mem_wdata_i,
    output logic [DATA_W-1:0]      mem_rdata_o,
    output logic                   mem_ack_o,
    output logic                   stallreq_o,
    output logic                   ram_ce_o,
    output logic                   ram_we_o,
    output logic [3:0]             ram_sel_o,
    output logic [DATA_W-1:0]      ram_addr_o,
    output logic [DATA_W-1:0]      ram_wdata_o,
    input  logic [DATA_W-1:0]      ram_rdata_i
);

    localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    arb_state_t       state, state_nxt;
    arb_owner_t       owner;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_if, grant_mem, last_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ArbIdle;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        last_beat = 1'b0;
        unique case (state)
            ArbIdle: begin
                // Fetch only overrides data when both are asking and fetch is starved.
                if (mem_req_i && !(if_req_i && starve_cnt == STARVE_LIM)) grant_mem = 1'b1;
                else if (if_req_i)                                        grant_if  = 1'b1;
                if (grant_mem || grant_if) state_nxt = ArbBusy;
            end
            ArbBusy: begin
                if (lat_cnt == CNT_W'(1)) begin
                    last_beat = 1'b1;
                    state_nxt = ArbDone;
                end
            end
            // The dead cycle lets a requester drop its req after the ack
            // before the next arbitration.
            ArbDone: state_nxt = ArbIdle;
            default: state_nxt = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner       <= OwnNone;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            ram_ce_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_sel_o   <= 4'h0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            if_data_o   <= '0;
            if_ack_o    <= 1'b0;
            mem_rdata_o <= '0;
            mem_ack_o   <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;

            if (grant_mem) begin
                owner       <= OwnMem;
                ram_ce_o    <= 1'b1;
                ram_we_o    <= mem_we_i;
                ram_sel_o   <= mem_sel_i;
                ram_addr_o  <= mem_addr_i;
                ram_wdata_o <= mem_wdata_i;
                lat_cnt     <= LAT_INIT;
                // Only a grant that actually beats a waiting fetch counts as a loss.
                if (if_req_i && starve_cnt != CNT_SAT) starve_cnt <= starve_cnt + CNT_W'(1);
            end

            if (grant_if) begin
                owner       <= OwnIf;
                ram_ce_o    <= 1'b1;
                ram_we_o    <= 1'b0;
                ram_sel_o   <= 4'hF;
                ram_addr_o  <= if_addr_i;
                ram_wdata_o <= '0;
                lat_cnt     <= LAT_INIT;
                starve_cnt  <= '0;
            end

            if (state == ArbBusy) lat_cnt <= lat_cnt - CNT_W'(1);

            if (last_beat) begin
                ram_ce_o <= 1'b0;
                if (owner == OwnIf) begin
                    if_data_o <= ram_rdata_i;
                    if_ack_o  <= 1'b1;
                end else if (owner == OwnMem) begin
                    if (!ram_we_o) mem_rdata_o <= ram_rdata_i;
                    mem_ack_o <= 1'b1;
                end
            end

            if (state == ArbDone) owner <= OwnNone;
        end
    end

    assign stallreq_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule

// File: doc/sopc_mem_arbiter.md
# sopc_mem_arbiter

Arbitrates one single-port unified program/data RAM between the CPU's instruction-fetch port and its data (MEM-stage) port inside the minimal SOPC. It sits between the openmips core and the RAM, in place of the direct ROM connection. It serialises accesses, tracks the RAM's fixed read latency and raises a stall request to the core's pipeline controller while any access is outstanding. Data accesses have priority; an anti-starvation counter guarantees instruction-fetch progress.

## Interface
- `MEM_LAT`, 2: RAM cycles from `ram_ce_o` assertion to valid `ram_rdata_i`. Legal range is 1..15.
- `STARVE_MAX`, 4: number of consecutive lost arbitrations after which fetch is forced to win. Legal range is 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous assert, active-low. Deassertion is synchronised externally.
- `if_req_i` in 1: fetch request, held until `if_ack_o`.
- `if_addr_i` in 32: fetch byte address (`InstAddrBus`).
- `if_data_o` out 32: fetched instruction (`InstBus`).
- `if_ack_o` out 1: one-cycle completion pulse.
- `mem_req_i` in 1: data request, held until `mem_ack_o`.
- `mem_we_i` in 1: 1 = write.
- `mem_sel_i` in 4: byte enables.
- `mem_addr_i` in 32: data byte address.
- `mem_wdata_i` in 32: write data.
- `mem_rdata_o` out 32: read data.
- `mem_ack_o` out 1: one-cycle completion pulse.
- `stallreq_o` out 1: pipeline stall request to ctrl.
- `ram_ce_o` out 1: RAM chip enable.
- `ram_we_o` out 1: RAM write enable.
- `ram_sel_o` out 4: RAM byte enables.
- `ram_addr_o` out 32: RAM address.
- `ram_wdata_o` out 32: RAM write data.
- `ram_rdata_i` in 32: RAM read data.

## Operation
- **States:** IDLE, BUSY, DONE. A 2-bit register records the owner (NONE/IF/MEM).
- **IDLE:**
  - If no request is active, stay in IDLE.
  - Otherwise grant per the priority rule below, latch the owner's address, we, sel and wdata, load the latency counter with `MEM_LAT`, and go to BUSY.
- **Priority:** MEM wins if both request, unless `starve_cnt == STARVE_MAX`, in which case IF wins.
  - `starve_cnt` increments (saturating) on each grant to MEM while `if_req_i` is high.
  - `starve_cnt` clears on any IF grant.
- **BUSY:**
  - `ram_ce_o` = 1; `ram_addr_o`, `ram_we_o`, `ram_sel_o` and `ram_wdata_o` are held stable from the latched values.
  - For IF grants, `ram_we_o` = 0 and `ram_sel_o` = 4'hF.
  - The counter decrements every cycle. On the cycle the counter equals 1:
    - sample `ram_rdata_i` into the owner's data output, unless the access is a write, in which case `mem_rdata_o` holds its previous value;
    - go to DONE.
- **DONE:**
  - `ram_ce_o` = 0; the owner's ack is 1 for exactly this cycle.
  - Go to IDLE unconditionally. The dead cycle prevents a stale, not-yet-dropped request from being regranted.
- **`stallreq_o`** = `(if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o)`. This is combinational and is the only combinational output.
- **Requester drops `req` before ack** (protocol violation): the transaction still completes and ack still pulses. No abort path exists.
- **Reset** (asynchronous, including mid-transaction):
  - state returns to IDLE, owner to NONE, counters to 0;
  - every registered output goes to 0 immediately, including `ram_ce_o` and both ack and data outputs;
  - the interrupted access produces no ack.

## Timing
- Request sampled in IDLE in cycle T:
  - BUSY covers T+1..T+MEM_LAT;
  - ack in T+MEM_LAT+1;
  - IDLE in T+MEM_LAT+2.
- Throughput is one access per MEM_LAT+2 cycles.
- The data outputs are valid in the ack cycle and hold until the next completion for the same port.
- With `MEM_LAT` = 1, BUSY lasts exactly one cycle.
- A request arriving while another is in BUSY or DONE waits. It is arbitrated in the next IDLE cycle.

## Structure
- Bus widths (`InstAddrBus`, `InstBus`, `DataBus`) come from the shared `define.v`.
- Add the following to `define.v`:
  - state encodings `ArbIdle`, `ArbBusy`, `ArbDone`;
  - owner encodings `OwnNone`, `OwnIf`, `OwnMem`.
- Single module, no sub-modules. The priority/starvation logic is small enough to stay inline.

## Test plan
- **Single fetch:** with `MEM_LAT`=2, raise `if_req_i` with `if_addr_i`=0x0000_0010 while RAM returns 0x3401_0020.
  - Required: `ram_ce_o` is high for 2 cycles; `if_ack_o` pulses 3 cycles after the request is sampled; `if_data_o`=0x3401_0020.
  - Required: `stallreq_o` is high from the request up to and excluding the ack cycle.
- **Data write:** `mem_we_i`=1, `mem_sel_i`=4'b0011, address 0x100, wdata 0xDEAD_BEEF.
  - Required: RAM sees `we`=1, `sel`=0011 and the given address/data throughout BUSY; `mem_ack_o` pulses once; `mem_rdata_o` is unchanged.
- **Simultaneous requests:** raise both requests in the same cycle. Required: MEM completes first; IF is granted in the IDLE cycle after DONE.
- **Starvation:** hold `if_req_i` high while `mem_req_i` re-requests continuously, with `STARVE_MAX`=4. Required: after 4 MEM grants, the 5th grant goes to IF; `starve_cnt` then returns to 0.
- **Reset mid-BUSY:** drive `rst` low during the first BUSY cycle. Required: `ram_ce_o` and all outputs go to 0 without waiting for a clock edge; no ack is produced; after release, a new request completes normally.
- **`MEM_LAT`=1 back-to-back fetches:** issue consecutive IF requests. Required: acks arrive every 3 cycles, each with the correct data.
